mem_port_arbiter: RTL and testbench

- Responder for the pipeline's two memory request ports: mem1 is instruction fetch (read only) and mem2 is data (LDR/LDB/LDI reads, STR/STB/STI writes).
- Serialises both ports onto one physical memory interface (pmem) and returns a one-cycle response pulse plus read data to the port that was served.
- Sits between the datapath's IF/MEM stages and the memory or cache.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Word, byte-mask and arbiter state definitions.
package mem_port_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    localparam int            STARVE_LIMIT_DEF = 2;
    localparam lc3b_mem_wmask WMASK_WORD       = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and physical memory signals.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic          mem1_read;
    lc3b_word      mem1_address;
    lc3b_word      mem1_rdata;
    logic          mem1_resp;

    logic          mem2_read;
    logic          mem2_write;
    lc3b_word      mem2_address;
    lc3b_word      mem2_wdata;
    lc3b_mem_wmask mem2_wmask;
    lc3b_word      mem2_rdata;
    logic          mem2_resp;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_word      pmem_wdata;
    lc3b_mem_wmask pmem_wmask;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem1_read, mem1_address,
        output mem1_rdata, mem1_resp,
        input  mem2_read, mem2_write, mem2_address,
        input  mem2_wdata, mem2_wmask,
        output mem2_rdata, mem2_resp,
        output pmem_read, pmem_write, pmem_address,
        output pmem_wdata, pmem_wmask,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem1_read, mem1_address,
        input  mem1_rdata, mem1_resp,
        output mem2_read, mem2_write, mem2_address,
        output mem2_wdata, mem2_wmask,
        input  mem2_rdata, mem2_resp,
        input  pmem_read, pmem_write, pmem_address,
        input  pmem_wdata, pmem_wmask,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (mem1) and data (mem2) ports onto one pmem port,
// data wins ties unless fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int CW =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_rd;
    logic          r_wr;
    lc3b_word      r_addr;
    lc3b_word      r_wdata;
    lc3b_mem_wmask r_wmask;

    logic w_req_d;
    logic w_starved;
    logic w_pick_d;
    logic w_resp_i;
    logic w_resp_d;

    assign w_req_d   = bus.mem2_read | bus.mem2_write;
    assign w_starved = (r_starve_cnt >= LIMIT);
    assign w_pick_d  = w_req_d & (~bus.mem1_read | ~w_starved);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state <= SERVE_D;
                        r_addr  <= bus.mem2_address;
                        r_wdata <= bus.mem2_wdata;
                        r_wmask <= bus.mem2_wmask;
                        // write dominates a read+write request
                        r_wr    <= bus.mem2_write;
                        r_rd    <= bus.mem2_read & ~bus.mem2_write;
                    end else if (bus.mem1_read) begin
                        r_state <= SERVE_I;
                        r_addr  <= bus.mem1_address;
                        r_wdata <= '0;
                        r_wmask <= WMASK_WORD;
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (bus.pmem_resp) begin
                        r_state      <= IDLE;
                        r_rd         <= 1'b0;
                        r_wr         <= 1'b0;
                        r_starve_cnt <= '0;
                    end
                end
                SERVE_D: begin
                    if (bus.pmem_resp) begin
                        r_state <= IDLE;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        if (bus.mem1_read && !w_starved)
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_resp_i = (r_state == SERVE_I) & bus.pmem_resp;
    assign w_resp_d = (r_state == SERVE_D) & bus.pmem_resp;

    assign bus.pmem_read    = r_rd;
    assign bus.pmem_write   = r_wr;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.pmem_wmask   = r_wmask;

    assign bus.mem1_resp  = w_resp_i;
    assign bus.mem1_rdata = w_resp_i ? bus.pmem_rdata : '0;
    assign bus.mem2_resp  = w_resp_d;
    assign bus.mem2_rdata =
        (w_resp_d & ~r_wr) ? bus.pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and a latency
// memory, checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    lc3b_word mem_m [lc3b_word];
    int order[$];

    int starve_m = 0;
    int gnt = 0;
    int pend = 0;
    int mcnt = 0;
    int mlat = 1;
    int lat_fix = 1;
    int n_resp1 = 0;
    int n_resp2 = 0;
    lc3b_word      g_addr, g_wd;
    lc3b_mem_wmask g_wm;
    logic          g_wr;
    logic s_resp1, s_resp2;
    lc3b_word s_rd1, s_rd2;

    function automatic lc3b_word mrd(lc3b_word a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 16'h5A5A;
    endfunction

    task automatic step();
        logic p_r1, p_r2r, p_r2w, p_st, s, was_resp, resp;
        lc3b_word p_a1, p_a2, p_wd, old, nw, rv;
        lc3b_mem_wmask p_wm;
        int eg;
        p_r1 = bus.mem1_read;  p_a1 = bus.mem1_address;
        p_r2r = bus.mem2_read; p_r2w = bus.mem2_write;
        p_a2 = bus.mem2_address; p_wd = bus.mem2_wdata;
        p_wm = bus.mem2_wmask;
        p_st = bus.pmem_read | bus.pmem_write;
        @(posedge clk); #1;
        was_resp = (pend != 0);
        if (pend == 1) starve_m = 0;
        else if (pend == 2 && p_r1 && starve_m < LIM) starve_m++;
        pend = 0;
        checks++;
        if (int'(dut.r_starve_cnt) !== starve_m) begin
            errors++;
            $display("FAIL starve_cnt got=%0d exp=%0d",
                     dut.r_starve_cnt, starve_m);
        end
        s = bus.pmem_read | bus.pmem_write;
        if (!p_st) begin
            eg = 0;
            if ((p_r2r || p_r2w) && (!p_r1 || starve_m < LIM)) eg = 2;
            else if (p_r1) eg = 1;
            checks++;
            if (s !== (eg != 0)) begin
                errors++;
                $display("FAIL grant strobe got=%b exp_grant=%0d", s, eg);
            end
            if (eg == 1) begin
                checks++;
                if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 ||
                    bus.pmem_address !== p_a1 ||
                    bus.pmem_wmask !== 2'b11) begin
                    errors++;
                    $display("FAIL fetch_grant got r=%b w=%b a=%h m=%b exp a=%h",
                             bus.pmem_read, bus.pmem_write,
                             bus.pmem_address, bus.pmem_wmask, p_a1);
                end
                g_addr = p_a1; g_wr = 1'b0;
            end else if (eg == 2) begin
                checks++;
                if (bus.pmem_write !== p_r2w ||
                    bus.pmem_read !== (p_r2r & ~p_r2w) ||
                    bus.pmem_address !== p_a2 ||
                    bus.pmem_wdata !== p_wd ||
                    bus.pmem_wmask !== p_wm) begin
                    errors++;
                    $display("FAIL data_grant got r=%b w=%b a=%h d=%h m=%b exp w=%b a=%h d=%h m=%b",
                             bus.pmem_read, bus.pmem_write,
                             bus.pmem_address, bus.pmem_wdata,
                             bus.pmem_wmask, p_r2w, p_a2, p_wd, p_wm);
                end
                g_addr = p_a2; g_wd = p_wd; g_wm = p_wm; g_wr = p_r2w;
            end
            gnt = eg; mcnt = 0;
            mlat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
            if (eg != 0) order.push_back(eg);
        end else begin
            checks++;
            if (was_resp ? (s !== 1'b0)
                         : (s !== 1'b1 || bus.pmem_address !== g_addr)) begin
                errors++;
                $display("FAIL hold_or_idle got strobe=%b a=%h exp a=%h done=%b",
                         s, bus.pmem_address, g_addr, was_resp);
            end
        end
        if (gnt != 0) mcnt++;
        resp = (gnt != 0) && (mcnt == mlat);
        rv = g_wr ? (lc3b_word'($urandom) | 16'h0001) : mrd(g_addr);
        bus.pmem_resp  = resp;
        bus.pmem_rdata = resp ? rv : lc3b_word'($urandom);
        #1;
        s_resp1 = bus.mem1_resp; s_resp2 = bus.mem2_resp;
        s_rd1 = bus.mem1_rdata;  s_rd2 = bus.mem2_rdata;
        checks++;
        if (s_resp1 !== (resp && gnt == 1) ||
            s_resp2 !== (resp && gnt == 2)) begin
            errors++;
            $display("FAIL resp got r1=%b r2=%b exp r1=%b r2=%b",
                     s_resp1, s_resp2, resp && gnt == 1, resp && gnt == 2);
        end
        checks++;
        if (s_rd1 !== ((resp && gnt == 1) ? rv : 16'h0)) begin
            errors++;
            $display("FAIL mem1_rdata got=%h exp=%h", s_rd1,
                     (resp && gnt == 1) ? rv : 16'h0);
        end
        if (!(resp && gnt == 2 && g_wr && g_wm !== 2'b00 &&
              !(p_r2r && p_r2w))) begin
            checks++;
            if (s_rd2 !== ((resp && gnt == 2 && !g_wr) ? rv : 16'h0)) begin
                errors++;
                $display("FAIL mem2_rdata got=%h exp=%h", s_rd2,
                         (resp && gnt == 2 && !g_wr) ? rv : 16'h0);
            end
        end
        if (resp) begin
            if (gnt == 2 && g_wr) begin
                old = mrd(g_addr);
                nw[15:8] = g_wm[1] ? g_wd[15:8] : old[15:8];
                nw[7:0]  = g_wm[0] ? g_wd[7:0]  : old[7:0];
                mem_m[g_addr] = nw;
            end
            if (gnt == 1) begin
                bus.mem1_read = 1'b0; n_resp1++;
            end else begin
                bus.mem2_read = 1'b0; bus.mem2_write = 1'b0; n_resp2++;
            end
            pend = gnt; gnt = 0;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((bus.mem1_read || bus.mem2_read || bus.mem2_write ||
                gnt != 0) && k < budget) begin
            step(); k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL drain_timeout budget=%0d", budget);
        end
        step(); step();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
            bus.pmem_address !== 16'h0 || bus.pmem_wdata !== 16'h0 ||
            bus.pmem_wmask !== 2'b00 || bus.mem1_resp !== 1'b0 ||
            bus.mem2_resp !== 1'b0 || bus.mem1_rdata !== 16'h0 ||
            bus.mem2_rdata !== 16'h0 || dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state r=%b w=%b a=%h st=%0d",
                     bus.pmem_read, bus.pmem_write,
                     bus.pmem_address, dut.r_state);
        end
    endtask

    task automatic test_simultaneous();
        order.delete();
        bus.mem1_read = 1'b1; bus.mem1_address = 16'h0010;
        bus.mem2_read = 1'b1; bus.mem2_address = 16'h0020;
        @(negedge clk); rst_n = 1'b1;
        lat_fix = 2;
        drain(40);
        checks++;
        if (order.size() != 2 || order[0] != 2 || order[1] != 1) begin
            errors++;
            $display("FAIL simultaneous_order got size=%0d first=%0d exp D,I",
                     order.size(), order.size() > 0 ? order[0] : -1);
        end
    endtask

    task automatic test_single_fetch();
        lat_fix = 1;
        mem_m[16'h0040] = 16'h1234;
        bus.mem1_read = 1'b1; bus.mem1_address = 16'h0040;
        step();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0040 ||
            s_resp1 !== 1'b1 || s_rd1 !== 16'h1234) begin
            errors++;
            $display("FAIL single_fetch got r=%b a=%h resp=%b d=%h exp 1/0040/1/1234",
                     bus.pmem_read, bus.pmem_address, s_resp1, s_rd1);
        end
        step();
        checks++;
        if (s_resp1 !== 1'b0 || s_rd1 !== 16'h0) begin
            errors++;
            $display("FAIL single_fetch_pulse got resp=%b d=%h exp 0/0000",
                     s_resp1, s_rd1);
        end
        drain(10);
    endtask

    task automatic test_byte_store();
        int r1;
        lat_fix = 2;
        r1 = n_resp1;
        bus.mem2_write = 1'b1; bus.mem2_address = 16'h0101;
        bus.mem2_wdata = 16'hAB00; bus.mem2_wmask = 2'b10;
        step();
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 ||
            bus.pmem_address !== 16'h0101 ||
            bus.pmem_wdata !== 16'hAB00 || bus.pmem_wmask !== 2'b10) begin
            errors++;
            $display("FAIL byte_store got w=%b a=%h d=%h m=%b",
                     bus.pmem_write, bus.pmem_address,
                     bus.pmem_wdata, bus.pmem_wmask);
        end
        drain(10);
        checks++;
        if (n_resp1 != r1 || mem_m[16'h0101] !== 16'hAB5B) begin
            errors++;
            $display("FAIL byte_store_effect got mem=%h r1=%0d exp AB5B r1=%0d",
                     mem_m[16'h0101], n_resp1, r1);
        end
    endtask

    task automatic test_starvation();
        int k;
        bit seen;
        order.delete();
        lat_fix = 1;
        seen = 0;
        bus.mem1_read = 1'b1; bus.mem1_address = 16'h0200;
        bus.mem2_read = 1'b1; bus.mem2_address = 16'h0300;
        for (k = 0; k < 60 && bus.mem1_read; k++) begin
            step();
            if (!seen && order.size() == 3) begin
                seen = 1;
                checks++;
                if (int'(dut.r_starve_cnt) !== 2 || order[2] != 1) begin
                    errors++;
                    $display("FAIL starve_grant got cnt=%0d grant=%0d exp 2/I",
                             dut.r_starve_cnt, order[2]);
                end
            end
            if (s_resp2 && order.size() < 3) begin
                bus.mem2_read = 1'b1;
                bus.mem2_address = bus.mem2_address + 16'h2;
            end
        end
        step();
        checks++;
        if (order.size() < 3 || order[0] != 2 || order[1] != 2 ||
            dut.r_starve_cnt !== '0) begin
            errors++;
            $display("FAIL starve_order got size=%0d cnt=%0d exp D,D,I cnt=0",
                     order.size(), dut.r_starve_cnt);
        end
        drain(20);
    endtask

    task automatic test_rw_illegal();
        lat_fix = 1;
        bus.mem2_read = 1'b1; bus.mem2_write = 1'b1;
        bus.mem2_address = 16'h0404; bus.mem2_wdata = 16'hC0DE;
        bus.mem2_wmask = 2'b11;
        step();
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 ||
            s_resp2 !== 1'b1 || s_rd2 !== 16'h0) begin
            errors++;
            $display("FAIL rw_illegal got w=%b r=%b resp=%b d=%h exp 1/0/1/0000",
                     bus.pmem_write, bus.pmem_read, s_resp2, s_rd2);
        end
        drain(10);
    endtask

    task automatic test_reset_mid_access();
        int r1;
        lat_fix = 3;
        mem_m[16'h0040] = 16'hBEEF;
        bus.mem1_read = 1'b1; bus.mem1_address = 16'h0040;
        step(); step();
        r1 = n_resp1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h0 ||
            bus.pmem_wmask !== 2'b00 || bus.mem1_resp !== 1'b0 ||
            dut.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid got r=%b a=%h resp=%b st=%0d",
                     bus.pmem_read, bus.pmem_address,
                     bus.mem1_resp, dut.r_state);
        end
        gnt = 0; pend = 0; starve_m = 0;
        #1 rst_n = 1'b1;
        drain(20);
        checks++;
        if (n_resp1 != r1 + 1) begin
            errors++;
            $display("FAIL reset_restart got resps=%0d exp=%0d",
                     n_resp1 - r1, 1);
        end
    endtask

    task automatic test_random();
        lat_fix = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (!bus.mem1_read && $urandom_range(0, 2) == 0) begin
                bus.mem1_read = 1'b1;
                bus.mem1_address = lc3b_word'($urandom_range(0, 31));
            end
            if (!bus.mem2_read && !bus.mem2_write &&
                $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.mem2_read = 1'b1;
                    1: bus.mem2_write = 1'b1;
                    2: bus.mem2_write = 1'b1;
                    default: begin
                        bus.mem2_read = 1'b1; bus.mem2_write = 1'b1;
                    end
                endcase
                bus.mem2_address = lc3b_word'($urandom_range(0, 31));
                bus.mem2_wdata = lc3b_word'($urandom);
                bus.mem2_wmask = lc3b_mem_wmask'($urandom_range(1, 3));
            end
        end
        drain(50);
    endtask

    initial begin
        bus.mem1_read = 1'b0; bus.mem1_address = '0;
        bus.mem2_read = 1'b0; bus.mem2_write = 1'b0;
        bus.mem2_address = '0; bus.mem2_wdata = '0;
        bus.mem2_wmask = 2'b11;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_byte_store();
        test_starvation();
        test_rw_illegal();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
